fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It issues requests to the instruction cache, holds a fetched word while the pipeline is stalled, and applies branch/jump redirects from later stages. Its outputs drive the IF/ID register's data inputs and its enable and flush controls.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/fetch_decode_if.sv | 45 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: machine word, fetch FSM states and
// the sequential instruction step.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_decode_if.sv
// Boundary between instruction fetch and the IF/ID pipeline register.
// The master side is the fetch unit: it receives the hazard/redirect
// controls and drives the instruction, its address and the IF/ID
// valid/flush controls. The slave side is the decode stage.
interface fetch_decode_if;
    import cpu_types_pkg::*;

    // Controls flowing back into fetch.
    logic  stall;
    logic  redirect;
    word_t redirect_addr;
    logic  halt;

    // Fetched instruction and IF/ID controls.
    logic  fd_valid;
    logic  fd_flush;
    word_t fd_instr;
    word_t fd_pc;
    word_t fd_next_addr;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_addr,
        input  halt,
        output fd_valid,
        output fd_flush,
        output fd_instr,
        output fd_pc,
        output fd_next_addr
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_addr,
        output halt,
        input  fd_valid,
        input  fd_flush,
        input  fd_instr,
        input  fd_pc,
        input  fd_next_addr
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, requests words from the icache,
// buffers a returned word while decode is stalled, and applies redirects.
// A redirect that arrives while an icache access is outstanding is parked
// in redir_pc so the request address stays stable until the access ends.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  word_t           imemload,
    output logic            imemREN,
    output word_t           imemaddr,
    fetch_decode_if.master  fd
);

    fetch_state_t state_reg, state_next;
    word_t        pc_reg, pc_next;
    word_t        redir_pc_reg, redir_pc_next;
    word_t        buf_reg, buf_next;

    logic         ren_raw;
    logic         valid_raw;
    word_t        instr_sel;

    // State and datapath registers; reset loads the start address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= FETCH;
            pc_reg       <= PC_INIT;
            redir_pc_reg <= '0;
            buf_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            redir_pc_reg <= redir_pc_next;
            buf_reg      <= buf_next;
        end
    end

    // Next-state and output decode; halt overrides everything, then redirect.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        redir_pc_next = redir_pc_reg;
        buf_next      = buf_reg;
        ren_raw       = 1'b0;
        valid_raw     = 1'b0;
        instr_sel     = imemload;

        case (state_reg)
            FETCH: begin
                ren_raw   = 1'b1;
                valid_raw = ihit & ~fd.redirect;
                if (fd.redirect) begin
                    if (ihit) begin
                        // Word for the wrong path is dropped; restart at once.
                        pc_next = fd.redirect_addr;
                    end else begin
                        // Access in flight: keep the address until it lands.
                        redir_pc_next = fd.redirect_addr;
                        state_next    = DRAIN;
                    end
                end else if (ihit) begin
                    if (fd.stall) begin
                        buf_next   = imemload;
                        state_next = HOLD;
                    end else begin
                        pc_next = pc_reg + PC_STEP;
                    end
                end
            end

            HOLD: begin
                valid_raw = 1'b1;
                instr_sel = buf_reg;
                if (fd.redirect) begin
                    pc_next    = fd.redirect_addr;
                    state_next = FETCH;
                end else if (!fd.stall) begin
                    pc_next    = pc_reg + PC_STEP;
                    state_next = FETCH;
                end
            end

            DRAIN: begin
                ren_raw = 1'b1;
                if (ihit) begin
                    // The latest redirect target wins, even one arriving now.
                    pc_next    = fd.redirect ? fd.redirect_addr : redir_pc_reg;
                    state_next = FETCH;
                end else if (fd.redirect) begin
                    redir_pc_next = fd.redirect_addr;
                end
            end

            HALTED: begin
                ren_raw = 1'b0;
            end

            default: begin
                state_next = FETCH;
            end
        endcase

        if (fd.halt) begin
            state_next    = HALTED;
            pc_next       = pc_reg;
            redir_pc_next = redir_pc_reg;
            buf_next      = buf_reg;
            valid_raw     = 1'b0;
        end
    end

    // Handshake outputs are forced inactive while reset is held.
    assign imemREN         = ren_raw & ~RST;
    assign imemaddr        = pc_reg;
    assign fd.fd_valid     = valid_raw & ~RST;
    assign fd.fd_instr     = instr_sel;
    assign fd.fd_pc        = pc_reg;
    assign fd.fd_next_addr = pc_reg + PC_STEP;
    assign fd.fd_flush     = fd.redirect & (state_reg != HALTED) & ~RST;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, all compared against a behavioural fetch model.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0040;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;

    fetch_decode_if fd_bus ();

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ihit     (ihit),
        .imemload (imemload),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .fd       (fd_bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    // Behavioural model: where fetch is, what it is waiting for.
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_hold;
    logic [31:0] m_hold_word;
    logic        m_drain;
    logic [31:0] m_drain_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc           = PC_INIT;
        m_halted       = 1'b0;
        m_hold         = 1'b0;
        m_hold_word    = '0;
        m_drain        = 1'b0;
        m_drain_target = '0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input logic r, input logic ih, input logic st, input logic rd,
                        input logic [31:0] ra, input logic hl, input logic [31:0] ld);
        logic [31:0] e_pc;
        logic        e_ren;
        logic        e_valid;
        logic        e_flush;
        logic [31:0] e_instr;
        @(negedge CLK);
        RST                  = r;
        ihit                 = ih;
        imemload             = ld;
        fd_bus.stall         = st;
        fd_bus.redirect      = rd;
        fd_bus.redirect_addr = ra;
        fd_bus.halt          = hl;
        #1;
        if (r) begin
            e_pc    = PC_INIT;
            e_ren   = 1'b0;
            e_valid = 1'b0;
            e_flush = 1'b0;
        end else begin
            e_pc    = m_pc;
            e_ren   = !m_halted && !m_hold;
            e_valid = !hl && !m_halted && (m_hold || (!m_drain && ih && !rd));
            e_flush = rd && !m_halted;
        end
        e_instr = m_hold ? m_hold_word : ld;
        $display("cyc rst=%0b ihit=%0b stall=%0b redir=%0b halt=%0b addr=%h ren=%0b valid=%0b instr=%h flush=%0b",
                 r, ih, st, rd, hl, imemaddr, imemREN, fd_bus.fd_valid, fd_bus.fd_instr, fd_bus.fd_flush);
        chk("imemREN", {31'd0, imemREN}, {31'd0, e_ren});
        chk("fd_valid", {31'd0, fd_bus.fd_valid}, {31'd0, e_valid});
        chk("fd_flush", {31'd0, fd_bus.fd_flush}, {31'd0, e_flush});
        chk("imemaddr", imemaddr, e_pc);
        chk("fd_pc", fd_bus.fd_pc, e_pc);
        chk("fd_next_addr", fd_bus.fd_next_addr, e_pc + 32'd4);
        if (e_valid) chk("fd_instr", fd_bus.fd_instr, e_instr);

        // Advance the model by the fetch rules.
        if (r) begin
            model_reset();
        end else if (m_halted) begin
            // only reset leaves halt
        end else if (hl) begin
            m_halted = 1'b1;
        end else if (m_hold) begin
            if (rd) begin
                m_pc   = ra;
                m_hold = 1'b0;
            end else if (!st) begin
                m_pc   = m_pc + 32'd4;
                m_hold = 1'b0;
            end
        end else if (m_drain) begin
            if (ih) begin
                m_pc    = rd ? ra : m_drain_target;
                m_drain = 1'b0;
            end else if (rd) begin
                m_drain_target = ra;
            end
        end else begin
            if (rd) begin
                if (ih) m_pc = ra;
                else begin
                    m_drain        = 1'b1;
                    m_drain_target = ra;
                end
            end else if (ih) begin
                if (st) begin
                    m_hold      = 1'b1;
                    m_hold_word = ld;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        RST                  = 1'b1;
        ihit                 = 1'b0;
        imemload             = '0;
        fd_bus.stall         = 1'b0;
        fd_bus.redirect      = 1'b0;
        fd_bus.redirect_addr = '0;
        fd_bus.halt          = 1'b0;
        model_reset();

        // Reset held.
        step(1, 1, 0, 0, 32'h0, 0, 32'h1111_1111);
        step(1, 0, 0, 0, 32'h0, 0, 32'h0);

        // Streaming: 0x40, 0x44, 0x48.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 0, $urandom);

        // Stall on a hit: hold the word for three cycles, then release.
        step(0, 1, 1, 0, 32'h0, 0, 32'h2008_0001);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h0, 0, $urandom);
        step(0, 0, 0, 0, 32'h0, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);

        // Move to pc 0x20, then redirect to 0x100 while the access is pending.
        step(0, 1, 0, 1, 32'h0000_0020, 0, $urandom);
        step(0, 0, 0, 1, 32'h0000_0100, 0, $urandom);
        step(0, 0, 0, 0, 32'h0, 0, $urandom);
        step(0, 0, 1, 0, 32'h0, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);

        // Redirect during HOLD wins over stall.
        step(0, 1, 1, 0, 32'h0, 0, 32'hDEAD_BEEF);
        step(0, 0, 1, 1, 32'h0000_0200, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);

        // Address wrap at the top of memory.
        step(0, 1, 0, 1, 32'hFFFF_FFFC, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);

        // Reset during a pending redirect.
        step(0, 0, 0, 1, 32'h0000_0300, 0, $urandom);
        step(1, 1, 0, 0, 32'h0, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);

        // Randomized traffic without halt.
        for (int i = 0; i < 300; i++) begin
            step(0,
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 12),
                 $urandom & 32'hFFFF_FFFC,
                 0,
                 $urandom);
        end

        // Halt with a hit, then random inputs stay ignored until reset.
        step(0, 1, 0, 0, 32'h0, 1, $urandom);
        for (int i = 0; i < 6; i++) begin
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom);
        end
        step(1, 0, 0, 0, 32'h0, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);
        step(0, 1, 0, 0, 32'h0, 0, $urandom);

        // Randomized traffic including occasional halt and reset.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 12),
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 99) < 2),
                 $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
